// File: rtl/ball_motion_if.sv
// Pixel-side bundle for the ball engine: VGA coordinates and game controls in,
// ball colour and game status out.
interface ball_motion_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active_pixels;
  logic [9:0]  paddle_x;
  logic        launch;
  logic        brick_bounce;
  logic [23:0] ball_color;
  logic [1:0]  lives;
  logic        miss_pulse;
  logic        game_over;

  modport master (
    output x, y, active_pixels, paddle_x, launch, brick_bounce,
    input  ball_color, lives, miss_pulse, game_over
  );

  modport slave (
    input  x, y, active_pixels, paddle_x, launch, brick_bounce,
    output ball_color, lives, miss_pulse, game_over
  );
endinterface

// File: rtl/ball_motion.sv
// Ball engine: per-frame position/velocity update, serve/miss/game-over sequencing,
// lives count and the per-pixel ball colour for the frame compositor.
module ball_motion #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PADDLE_Y    = 440,
  parameter int unsigned PADDLE_W    = 80,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned MISS_FRAMES = 60,
  parameter logic [23:0] BALL_COLOR  = 24'hFFFFFF
) (
  input logic          clk,
  input logic          rst,
  ball_motion_if.slave bus_io
);
  localparam int unsigned CntW = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

  localparam logic signed [11:0] Spd      = 12'(SPEED);
  localparam logic signed [11:0] Size     = 12'(BALL_SIZE);
  localparam logic signed [11:0] HalfSize = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] PadY     = 12'(PADDLE_Y);
  localparam logic signed [11:0] PadW     = 12'(PADDLE_W);
  localparam logic signed [11:0] HalfPadW = 12'(PADDLE_W / 2);
  localparam logic signed [11:0] ScrH     = 12'(SCREEN_H);
  localparam logic signed [11:0] XMax     = 12'(SCREEN_W - BALL_SIZE);

  localparam logic [9:0]      XMaxU    = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]      HomeOffs = 10'((PADDLE_W - BALL_SIZE) / 2);
  localparam logic [9:0]      RestY    = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0]      TickRow  = 10'(SCREEN_H);
  localparam logic [10:0]     SizeU    = 11'(BALL_SIZE);
  localparam logic [CntW-1:0] CntLast  = CntW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StMiss, StOver} state_e;

  state_e          state_q, state_d;
  logic [9:0]      bx_q, bx_d, by_q, by_d, y_prev_q;
  logic            vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [1:0]      lives_q, lives_d;
  logic            miss_pulse_q, miss_pulse_d;
  logic            pend_q, pend_d;
  logic [CntW-1:0] miss_cnt_q, miss_cnt_d;

  logic               tick;
  logic [10:0]        trk_sum;
  logic [9:0]         bx_home;
  logic signed [11:0] bx_s, by_s, pad_s, dvx, dvy, nx, ny;
  logic               hit_paddle, hit_left;

  // One tick per frame: first cycle the row counter sits on the blanking row.
  assign tick = (bus_io.y == TickRow) && (y_prev_q != TickRow);

  assign trk_sum = {1'b0, bus_io.paddle_x} + {1'b0, HomeOffs};
  assign bx_home = (trk_sum > {1'b0, XMaxU}) ? XMaxU : trk_sum[9:0];

  assign bx_s  = signed'({2'b00, bx_q});
  assign by_s  = signed'({2'b00, by_q});
  assign pad_s = signed'({2'b00, bus_io.paddle_x});
  assign dvx   = vx_neg_q ? -Spd : Spd;
  assign dvy   = vy_neg_q ? -Spd : Spd;
  assign nx    = bx_s + dvx;
  assign ny    = by_s + dvy;

  assign hit_paddle = !vy_neg_q && (by_s + Size <= PadY) && (ny + Size > PadY) &&
                      (nx + Size > pad_s) && (nx < pad_s + PadW);
  assign hit_left   = (bx_s + HalfSize) < (pad_s + HalfPadW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bx_q         <= HomeOffs;
      by_q         <= RestY;
      vx_neg_q     <= 1'b0;
      vy_neg_q     <= 1'b1;
      lives_q      <= 2'd3;
      miss_pulse_q <= 1'b0;
      pend_q       <= 1'b0;
      miss_cnt_q   <= '0;
      y_prev_q     <= '0;
    end else begin
      state_q      <= state_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      vx_neg_q     <= vx_neg_d;
      vy_neg_q     <= vy_neg_d;
      lives_q      <= lives_d;
      miss_pulse_q <= miss_pulse_d;
      pend_q       <= pend_d;
      miss_cnt_q   <= miss_cnt_d;
      y_prev_q     <= bus_io.y;
    end
  end

  always_comb begin
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    vx_neg_d     = vx_neg_q;
    vy_neg_d     = vy_neg_q;
    lives_d      = lives_q;
    miss_cnt_d   = miss_cnt_q;
    miss_pulse_d = 1'b0;
    pend_d       = pend_q | bus_io.brick_bounce;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          bx_d = bx_home;
          by_d = RestY;
          if (bus_io.launch) begin
            state_d  = StPlay;
            vx_neg_d = 1'b0;
            vy_neg_d = 1'b1;
          end
        end
        StPlay: begin
          pend_d = bus_io.brick_bounce;
          if (nx[11]) begin
            bx_d     = '0;
            vx_neg_d = 1'b0;
          end else if (nx > XMax) begin
            bx_d     = XMaxU;
            vx_neg_d = 1'b1;
          end else begin
            bx_d = nx[9:0];
          end
          // Vertical rules in priority order; the paddle beats a pending brick bounce.
          if (ny[11]) begin
            by_d     = '0;
            vy_neg_d = 1'b0;
          end else if (hit_paddle) begin
            by_d     = RestY;
            vy_neg_d = 1'b1;
            vx_neg_d = hit_left;
          end else if (pend_q) begin
            vy_neg_d = !vy_neg_q;
          end else if (ny + Size >= ScrH) begin
            miss_pulse_d = 1'b1;
            pend_d       = 1'b0;
            lives_d      = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
            if (lives_q <= 2'd1) begin
              state_d = StOver;
            end else begin
              state_d    = StMiss;
              miss_cnt_d = '0;
            end
          end else begin
            by_d = ny[9:0];
          end
        end
        StMiss: begin
          if (miss_cnt_q == CntLast) begin
            state_d = StIdle;
            bx_d    = bx_home;
            by_d    = RestY;
          end else begin
            miss_cnt_d = miss_cnt_q + CntW'(1);
          end
        end
        StOver: lives_d = '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_io.game_over  = (state_q == StOver);
    bus_io.ball_color = '0;
    if (bus_io.active_pixels && (state_q inside {StIdle, StPlay}) &&
        (bus_io.x >= bx_q) && ({1'b0, bus_io.x} < {1'b0, bx_q} + SizeU) &&
        (bus_io.y >= by_q) && ({1'b0, bus_io.y} < {1'b0, by_q} + SizeU)) begin
      bus_io.ball_color = BALL_COLOR;
    end
  end

  assign bus_io.lives      = lives_q;
  assign bus_io.miss_pulse = miss_pulse_q;
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: synthetic short frames, a game-rule model in plain integers,
// pixel probes around the expected ball square.
module tb_ball_motion;
  localparam int W = 640, H = 480, BS = 8, PY = 440, PW = 80, SP = 2, MF = 60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ball_motion_if bus ();
  ball_motion dut (.clk(clk), .rst(rst), .bus_io(bus));

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int px;

  always @(negedge clk) if (bus.miss_pulse === 1'b1) pulses++;

  // Model: mode 0 idle, 1 play, 2 miss, 3 over.
  int m_st, m_bx, m_by, m_vx, m_vy, m_lives, m_cnt;
  int m_misses = 0;
  bit m_pend;

  typedef struct { int px; int py; bit act; logic [23:0] exp; } vec_t;
  vec_t vecs [10];

  function automatic int home_x(int p);
    return (p + (PW - BS) / 2 > W - BS) ? W - BS : p + (PW - BS) / 2;
  endfunction

  task automatic model_reset();
    m_st = 0; m_bx = (PW - BS) / 2; m_by = PY - BS; m_vx = SP; m_vy = -SP;
    m_lives = 3; m_cnt = 0; m_pend = 0;
  endtask

  task automatic model_tick(int p, bit launch);
    int nx, ny, obx;
    case (m_st)
      0: begin
        m_bx = home_x(p); m_by = PY - BS;
        if (launch) begin m_st = 1; m_vx = SP; m_vy = -SP; end
      end
      1: begin
        obx = m_bx; nx = m_bx + m_vx; ny = m_by + m_vy;
        if (nx < 0) begin m_bx = 0; m_vx = SP; end
        else if (nx > W - BS) begin m_bx = W - BS; m_vx = -SP; end
        else m_bx = nx;
        if (ny < 0) begin m_by = 0; m_vy = SP; end
        else if (m_vy > 0 && m_by + BS <= PY && ny + BS > PY && nx + BS > p && nx < p + PW) begin
          m_by = PY - BS; m_vy = -SP;
          m_vx = (obx + BS / 2 < p + PW / 2) ? -SP : SP;
        end
        else if (m_pend) m_vy = -m_vy;
        else if (ny + BS >= H) begin
          m_misses++; m_lives--;
          if (m_lives == 0) m_st = 3; else begin m_st = 2; m_cnt = 0; end
        end
        else m_by = ny;
        m_pend = 0;
      end
      2: begin
        if (m_cnt == MF - 1) begin m_st = 0; m_bx = home_x(p); m_by = PY - BS; end
        else m_cnt++;
      end
      default: ;
    endcase
  endtask

  function automatic logic [23:0] exp_px(int qx, int qy, bit act);
    if (act && (m_st == 0 || m_st == 1) && qx >= m_bx && qx < m_bx + BS &&
        qy >= m_by && qy < m_by + BS) return 24'hFFFFFF;
    return 24'h000000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cpx(string name, int qx, int qy, logic [23:0] exp);
    bus.x = 10'(qx); bus.y = 10'(qy); bus.active_pixels = 1'b1; #1;
    chk(name, 32'(bus.ball_color), 32'(exp));
  endtask

  task automatic probe(string name, int qx, int qy, bit act);
    if (qx < 0 || qx > 1023 || qy < 0 || qy > 1023 || qy == H) return;
    bus.x = 10'(qx); bus.y = 10'(qy); bus.active_pixels = act; #1;
    chk(name, 32'(bus.ball_color), 32'(exp_px(qx, qy, act)));
    bus.active_pixels = 1'b1;
  endtask

  task automatic check_all(string name);
    chk({name, " lives"}, 32'(bus.lives), 32'(m_lives));
    chk({name, " over"}, 32'(bus.game_over), 32'(m_st == 3));
    chk({name, " pulses"}, 32'(pulses), 32'(m_misses));
    probe({name, " tl"}, m_bx, m_by, 1'b1);
    probe({name, " br"}, m_bx + BS - 1, m_by + BS - 1, 1'b1);
    probe({name, " left"}, m_bx - 1, m_by, 1'b1);
    probe({name, " right"}, m_bx + BS, m_by, 1'b1);
    probe({name, " above"}, m_bx, m_by - 1, 1'b1);
    probe({name, " below"}, m_bx, m_by + BS, 1'b1);
    probe({name, " blank"}, m_bx, m_by, 1'b0);
  endtask

  // Short synthetic frame: a few rows, then the blanking row held three cycles.
  task automatic frame(int p, bit launch, bit brick);
    bus.paddle_x = 10'(p); bus.launch = launch; bus.y = 10'd0;
    @(posedge clk); #1;
    if (brick) begin
      bus.brick_bounce = 1'b1; @(posedge clk); #1;
      bus.brick_bounce = 1'b0; m_pend = 1;
    end
    @(posedge clk); #1;
    bus.y = 10'(H);
    @(posedge clk); #1;
    model_tick(p, launch);
    repeat (2) @(posedge clk);
    #1;
    bus.launch = 1'b0; bus.y = 10'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.y = 10'd200; rst = 1'b1; #1;
    model_reset();
    check_all("in_rst");
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic miss_round(bit serve);
    if (serve) begin frame(300, 1'b1, 1'b0); check_all("serve"); end
    for (int i = 0; i < 600 && m_st == 1; i++) begin
      frame((m_bx >= 320) ? 0 : 560, 1'b0, 1'b0); check_all("fall");
    end
    for (int i = 0; i < 100 && m_st == 2; i++) begin
      frame(200, 1'b1, 1'b0); check_all("hidden");
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.x = '0; bus.y = '0; bus.active_pixels = 1'b1; bus.paddle_x = '0;
    bus.launch = 1'b0; bus.brick_bounce = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    vecs = '{'{36, 432, 1'b1, 24'hFFFFFF}, '{43, 439, 1'b1, 24'hFFFFFF},
             '{40, 436, 1'b1, 24'hFFFFFF}, '{35, 432, 1'b1, 24'h000000},
             '{44, 432, 1'b1, 24'h000000}, '{36, 431, 1'b1, 24'h000000},
             '{36, 440, 1'b1, 24'h000000}, '{40, 436, 1'b0, 24'h000000},
             '{0, 0, 1'b1, 24'h000000},    '{639, 479, 1'b1, 24'h000000}};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.x = 10'(vecs[i].px); bus.y = 10'(vecs[i].py); bus.active_pixels = vecs[i].act; #1;
      chk("reset_vec", 32'(bus.ball_color), 32'(vecs[i].exp));
    end
    bus.active_pixels = 1'b1;
    chk("reset_lives", 32'(bus.lives), 32'd3);
    chk("reset_over", 32'(bus.game_over), 32'd0);

    // Serve from the right and run into the right wall.
    frame(560, 1'b1, 1'b0); check_all("launch");
    for (int i = 0; i < 18; i++) begin frame(560, 1'b0, 1'b0); check_all("to_wall"); end
    cpx("wall_reach_in", 632, 396, 24'hFFFFFF);
    cpx("wall_reach_out", 631, 396, 24'h000000);
    frame(560, 1'b0, 1'b0); check_all("wall");
    cpx("wall_hold", 632, 394, 24'hFFFFFF);
    cpx("wall_hold_br", 639, 401, 24'hFFFFFF);
    frame(560, 1'b0, 1'b0); check_all("wall_back");
    cpx("wall_back_in", 630, 392, 24'hFFFFFF);
    cpx("wall_back_out", 638, 392, 24'h000000);

    for (int i = 0; i < 400 && m_vy < 0; i++) begin frame(560, 1'b0, 1'b0); check_all("climb"); end
    // Paddle centred on the ball: right-half contact.
    for (int i = 0; i < 400 && m_vy > 0; i++) begin
      px = (m_bx >= 36) ? m_bx - 36 : 0;
      frame(px, 1'b0, 1'b0); check_all("pad_right");
    end
    repeat (3) begin frame(300, 1'b0, 1'b0); check_all("rise"); end
    frame(300, 1'b0, 1'b1); check_all("brick_up");
    // Paddle offset right of the ball (left-half contact), with a brick on the contact frame.
    for (int i = 0; i < 400 && m_vy > 0; i++) begin
      px = (m_bx >= 30) ? m_bx - 30 : 0;
      frame(px, 1'b0, (m_by + BS <= PY) && (m_by + m_vy + BS > PY)); check_all("pad_left");
    end

    miss_round(1'b0);
    chk("lives_miss1", 32'(bus.lives), 32'd2);
    miss_round(1'b1);
    miss_round(1'b1);
    chk("lives_over", 32'(bus.lives), 32'd0);
    chk("flag_over", 32'(bus.game_over), 32'd1);
    repeat (3) begin frame(100, 1'b1, 1'b0); check_all("over_launch"); end
    do_reset();
    chk("lives_rst", 32'(bus.lives), 32'd3);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0 || (m_st == 3 && $urandom_range(0, 9) == 0)) do_reset();
      if ($urandom_range(0, 1) == 0) px = int'($urandom_range(0, 600));
      else px = (m_bx > 85) ? m_bx - int'($urandom_range(0, 85)) : int'($urandom_range(0, 40));
      frame(px, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
